// File: rtl/tipi_4bit_bus_master_if.sv
`default_nettype none
// ============================================================================
// Module      : tipi_4bit_bus_master_if
// Description : Host handshake and TIPI nibble-bus signals of the bus master.
// Revision    : 1.0 - initial release
// ============================================================================
interface tipi_4bit_bus_master_if;
    logic       start;
    logic [1:0] op;
    logic [7:0] wdata;
    logic       sync;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       bus_clk;
    logic       bus_rst;
    logic [3:0] bus_data_out;
    logic       bus_data_oe;
    logic [3:0] bus_data_in;

    modport master (
        input  start, op, wdata, sync, bus_data_in,
        output busy, done, rdata, bus_clk, bus_rst, bus_data_out, bus_data_oe
    );

    modport slave (
        output start, op, wdata, sync, bus_data_in,
        input  busy, done, rdata, bus_clk, bus_rst, bus_data_out, bus_data_oe
    );
endinterface
`default_nettype wire

// File: rtl/tipi_4bit_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : tipi_4bit_bus_master
// Description : TIPI 4-bit bus master; select nibble then one byte as two nibbles.
// Revision    : 1.0 - initial release
// ============================================================================
module tipi_4bit_bus_master #(
    parameter int HALF       = 4,
    parameter int RST_CYCLES = 8
) (
    input  wire logic               clk,
    input  wire logic               reset,
    tipi_4bit_bus_master_if.master  bus
);

    localparam int HW = $clog2(HALF + 1);
    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(HALF - 1);
    localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_IDLE = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    phase_q, phase_d;
    logic [HW-1:0] half_q, half_d;
    logic [RW-1:0] rst_cnt_q, rst_cnt_d;
    logic [1:0]    op_q, op_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          bus_clk_q, bus_clk_d;
    logic          bus_rst_q, bus_rst_d;
    logic [3:0]    out_q, out_d;
    logic          oe_q, oe_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          phase_start;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        half_d      = half_q;
        rst_cnt_d   = rst_cnt_q;
        op_d        = op_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        out_d       = out_q;
        oe_d        = oe_q;
        phase_start = 1'b0;

        case (state_q)
            ST_RST: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d   = ST_IDLE;
                    rst_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + RW'(1);
                end
            end
            ST_IDLE: begin
                // sync wins over a simultaneous start, which is dropped
                if (bus.sync) begin
                    state_d   = ST_RST;
                    rst_cnt_d = '0;
                end else if (bus.start) begin
                    state_d     = ST_XFER;
                    phase_d     = 3'd0;
                    half_d      = HALF_LAST;
                    op_d        = bus.op;
                    wdata_d     = bus.wdata;
                    phase_start = 1'b1;
                end
            end
            ST_XFER: begin
                if (half_q == '0 && !op_q[1]) begin
                    if (phase_q == 3'd4) rdata_d[7:4] = bus.bus_data_in;
                    if (phase_q == 3'd6) rdata_d[3:0] = bus.bus_data_in;
                end
                if (half_q != '0) begin
                    half_d = half_q - HW'(1);
                end else begin
                    half_d = HALF_LAST;
                    if (phase_q == 3'd6) begin
                        state_d = ST_DONE;
                    end else begin
                        phase_d     = phase_q + 3'd1;
                        phase_start = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_RST;
            end
        endcase

        // Outputs are registered from the next state so they line up with it
        bus_rst_d = (state_d == ST_RST);
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
        bus_clk_d = (state_d == ST_XFER) && phase_d[0];

        if (state_d != ST_XFER) oe_d = 1'b0;

        if (phase_start) begin
            case (phase_d)
                3'd0: begin
                    oe_d  = 1'b1;
                    out_d = {2'b00, op_d};
                end
                3'd2: begin
                    if (op_d[1]) out_d = wdata_d[7:4];
                    else         oe_d  = 1'b0;
                end
                3'd4: begin
                    if (op_d[1]) out_d = wdata_d[3:0];
                end
                3'd6: begin
                    if (op_d[1]) begin
                        oe_d  = 1'b0;
                        out_d = 4'h0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_RST;
            phase_q   <= 3'd0;
            half_q    <= '0;
            rst_cnt_q <= '0;
            op_q      <= 2'b00;
            wdata_q   <= 8'h00;
            rdata_q   <= 8'h00;
            bus_clk_q <= 1'b0;
            bus_rst_q <= 1'b1;
            out_q     <= 4'h0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            half_q    <= half_d;
            rst_cnt_q <= rst_cnt_d;
            op_q      <= op_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            bus_clk_q <= bus_clk_d;
            bus_rst_q <= bus_rst_d;
            out_q     <= out_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.rdata        = rdata_q;
    assign bus.bus_clk      = bus_clk_q;
    assign bus.bus_rst      = bus_rst_q;
    assign bus.bus_data_out = out_q;
    assign bus.bus_data_oe  = oe_q;

endmodule
`default_nettype wire

// File: tb/tb_tipi_4bit_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_tipi_4bit_bus_master
// Description : Bench for two masters (HALF=2 and HALF=1) with a nibble-bus slave model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tipi_4bit_bus_master;

    localparam int RSTC = 4;
    localparam int H0   = 2;
    localparam int H1   = 1;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;
    int   total   = 0;
    int   bad     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tipi_4bit_bus_master_if bus0();
    tipi_4bit_bus_master_if bus1();

    tipi_4bit_bus_master #(.HALF(H0), .RST_CYCLES(RSTC)) dut0 (
        .clk(clk), .reset(reset_n), .bus(bus0.master));
    tipi_4bit_bus_master #(.HALF(H1), .RST_CYCLES(RSTC)) dut1 (
        .clk(clk), .reset(reset_n), .bus(bus1.master));

    // Host-side stimulus and DUT observations, indexed by DUT
    logic       t_start [2] = '{1'b0, 1'b0};
    logic       t_sync  [2] = '{1'b0, 1'b0};
    logic [1:0] t_op    [2] = '{2'd0, 2'd0};
    logic [7:0] t_wdata [2] = '{8'd0, 8'd0};
    logic       o_busy [2], o_done [2], o_bclk [2], o_brst [2], o_oe [2];
    logic [7:0] o_rdata [2];
    logic [3:0] o_out [2];

    assign bus0.start = t_start[0];  assign bus1.start = t_start[1];
    assign bus0.sync  = t_sync[0];   assign bus1.sync  = t_sync[1];
    assign bus0.op    = t_op[0];     assign bus1.op    = t_op[1];
    assign bus0.wdata = t_wdata[0];  assign bus1.wdata = t_wdata[1];
    assign o_busy[0]  = bus0.busy;         assign o_busy[1]  = bus1.busy;
    assign o_done[0]  = bus0.done;         assign o_done[1]  = bus1.done;
    assign o_bclk[0]  = bus0.bus_clk;      assign o_bclk[1]  = bus1.bus_clk;
    assign o_brst[0]  = bus0.bus_rst;      assign o_brst[1]  = bus1.bus_rst;
    assign o_oe[0]    = bus0.bus_data_oe;  assign o_oe[1]    = bus1.bus_data_oe;
    assign o_out[0]   = bus0.bus_data_out; assign o_out[1]   = bus1.bus_data_out;
    assign o_rdata[0] = bus0.rdata;        assign o_rdata[1] = bus1.rdata;

    // Slave model: select on 1st bus_clk rise, data nibbles on 2nd and 3rd
    logic [7:0] s_td [2] = '{8'd0, 8'd0};
    logic [7:0] s_tc [2] = '{8'd0, 8'd0};
    logic [7:0] s_rd [2] = '{8'd0, 8'd0};
    logic [7:0] s_rc [2] = '{8'd0, 8'd0};
    logic [3:0] s_din [2] = '{4'd0, 4'd0};
    logic [3:0] s_sel [2] = '{4'd0, 4'd0};
    logic [3:0] s_hi  [2] = '{4'd0, 4'd0};
    logic [1:0] s_cnt [2] = '{2'd0, 2'd0};
    logic       s_prev [2] = '{1'b0, 1'b0};

    assign bus0.bus_data_in = s_din[0];
    assign bus1.bus_data_in = s_din[1];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            s_prev[k] <= o_bclk[k];
            if (o_brst[k]) begin
                s_cnt[k] <= 2'd0;
                s_din[k] <= 4'd0;
            end else if (o_bclk[k] && !s_prev[k]) begin
                case (s_cnt[k])
                    2'd0: begin
                        s_sel[k] <= o_oe[k] ? o_out[k] : 4'hF;
                        s_cnt[k] <= 2'd1;
                    end
                    2'd1: begin
                        if (s_sel[k] == 4'd0) s_din[k] <= s_td[k][7:4];
                        if (s_sel[k] == 4'd1) s_din[k] <= s_tc[k][7:4];
                        if (o_oe[k]) s_hi[k] <= o_out[k];
                        s_cnt[k] <= 2'd2;
                    end
                    default: begin
                        if (s_sel[k] == 4'd0) s_din[k] <= s_td[k][3:0];
                        if (s_sel[k] == 4'd1) s_din[k] <= s_tc[k][3:0];
                        if (o_oe[k] && s_sel[k] == 4'd2) s_rd[k] <= {s_hi[k], o_out[k]};
                        if (o_oe[k] && s_sel[k] == 4'd3) s_rc[k] <= {s_hi[k], o_out[k]};
                        s_cnt[k] <= 2'd0;
                    end
                endcase
            end
        end
    end

    // Cumulative bus observations sampled on the falling edge
    int rise [2] = '{0, 0};
    int clkhi [2] = '{0, 0};
    int oehi [2] = '{0, 0};
    int rsthi [2] = '{0, 0};
    int busyhi [2] = '{0, 0};
    int donecnt [2] = '{0, 0};
    int lastdone [2] = '{0, 0};
    int unstable [2] = '{0, 0};
    logic       m_clk [2] = '{1'b0, 1'b0};
    logic       m_oe  [2] = '{1'b0, 1'b0};
    logic [3:0] m_out [2] = '{4'd0, 4'd0};

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset_n) begin
                if (o_bclk[k] && !m_clk[k]) rise[k] <= rise[k] + 1;
                if (o_bclk[k]) clkhi[k] <= clkhi[k] + 1;
                if (o_oe[k])   oehi[k]  <= oehi[k] + 1;
                if (o_brst[k]) rsthi[k] <= rsthi[k] + 1;
                if (o_busy[k]) busyhi[k] <= busyhi[k] + 1;
                if (o_done[k]) begin
                    donecnt[k]  <= donecnt[k] + 1;
                    lastdone[k] <= cyc;
                end
                if (o_bclk[k] && (o_out[k] !== m_out[k] || o_oe[k] !== m_oe[k]))
                    unstable[k] <= unstable[k] + 1;
            end
            m_clk[k] <= o_bclk[k];
            m_oe[k]  <= o_oe[k];
            m_out[k] <= o_out[k];
        end
    end

    logic [7:0] exp_rdata [2] = '{8'd0, 8'd0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        while (o_busy[k] && n < 400) begin
            step();
            n++;
        end
        check("idle_wait", {31'd0, o_busy[k]}, 32'd0);
    endtask

    task automatic run_txn(input int k, input logic [1:0] op, input logic [7:0] wd,
                           input logic [7:0] td, input logic [7:0] tc, input bit pulse);
        int h;
        int c0, r0, ch0, oe0, d0;
        h = (k == 0) ? H0 : H1;
        wait_idle(k);
        s_td[k] = td;
        s_tc[k] = tc;
        r0 = rise[k]; ch0 = clkhi[k]; oe0 = oehi[k]; d0 = donecnt[k];
        t_start[k] = 1'b1;
        t_op[k]    = op;
        t_wdata[k] = wd;
        c0 = cyc;
        step();
        t_start[k] = 1'b0;
        t_op[k]    = ~op;
        t_wdata[k] = ~wd;
        if (pulse) begin
            step();
            t_start[k] = 1'b1;
            step();
            t_start[k] = 1'b0;
        end
        while (cyc < c0 + 7 * h + 8) step();

        if (op == 2'd0) exp_rdata[k] = td;
        if (op == 2'd1) exp_rdata[k] = tc;
        check("done_count", donecnt[k] - d0, 1);
        check("done_cycle", lastdone[k] - c0, 7 * h + 1);
        check("bclk_rises", rise[k] - r0, 3);
        check("bclk_high_cycles", clkhi[k] - ch0, 3 * h);
        check("oe_high_cycles", oehi[k] - oe0, op[1] ? 6 * h : 2 * h);
        check("slave_select", {28'd0, s_sel[k]}, {30'd0, op});
        check("rdata", {24'd0, o_rdata[k]}, {24'd0, exp_rdata[k]});
        if (op == 2'd2) check("slave_rd", {24'd0, s_rd[k]}, {24'd0, wd});
        if (op == 2'd3) check("slave_rc", {24'd0, s_rc[k]}, {24'd0, wd});
    endtask

    task automatic check_idle_outputs(input int k);
        check("idle_outputs", {28'd0, o_brst[k], o_busy[k], o_oe[k], o_bclk[k]}, 32'd0);
    endtask

    initial begin
        int rs0 [2];
        int bs0 [2];
        int d0 [2];
        int r0;
        int n;

        // Power-up: reset held low for three cycles
        step(); step(); step();
        for (int k = 0; k < 2; k++)
            check("reset_values",
                  {16'd0, o_rdata[k], o_out[k], o_brst[k], o_busy[k], o_done[k], o_oe[k], o_bclk[k]},
                  {16'd0, 8'h00, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        for (int k = 0; k < 2; k++) begin rs0[k] = rsthi[k]; bs0[k] = busyhi[k]; end
        reset_n = 1'b1;
        for (int i = 0; i < 3 * RSTC; i++) step();
        for (int k = 0; k < 2; k++) begin
            check("powerup_bus_rst_cycles", rsthi[k] - rs0[k], RSTC);
            check("powerup_busy_cycles", busyhi[k] - bs0[k], RSTC);
            check_idle_outputs(k);
        end

        // Directed cases from the plan
        run_txn(0, 2'd0, 8'h00, 8'hA5, 8'h11, 1'b0);
        run_txn(1, 2'd1, 8'h00, 8'h22, 8'h5A, 1'b0);
        run_txn(0, 2'd3, 8'h3C, 8'h77, 8'h66, 1'b0);
        run_txn(1, 2'd2, 8'hC3, 8'h00, 8'h00, 1'b1);

        // start and sync together: bus reset only, no transaction
        for (int k = 0; k < 2; k++) begin
            wait_idle(k);
            rs0[k] = rsthi[k]; d0[k] = donecnt[k]; r0 = rise[k];
            t_start[k] = 1'b1;
            t_sync[k]  = 1'b1;
            t_op[k]    = 2'd0;
            step();
            t_start[k] = 1'b0;
            t_sync[k]  = 1'b0;
            for (int i = 0; i < 3 * RSTC; i++) step();
            check("sync_bus_rst_cycles", rsthi[k] - rs0[k], RSTC);
            check("sync_no_done", donecnt[k] - d0[k], 0);
            check("sync_no_bclk", rise[k] - r0, 0);
            check_idle_outputs(k);
        end

        // Randomized transactions against the byte-level model
        for (int i = 0; i < 10; i++)
            run_txn(int'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
                    8'($urandom), 8'($urandom), 1'(i & 1));

        // Reset asserted during P3 of a read
        wait_idle(0);
        d0[0] = donecnt[0];
        s_td[0] = 8'($urandom);
        r0 = rise[0];
        t_start[0] = 1'b1;
        t_op[0]    = 2'd0;
        step();
        t_start[0] = 1'b0;
        n = 0;
        while (rise[0] - r0 < 2 && n < 100) begin
            step();
            n++;
        end
        check("p3_reached", rise[0] - r0, 2);
        reset_n = 1'b0;
        #1;
        check("midop_reset_outputs",
              {27'd0, o_bclk[0], o_oe[0], o_brst[0], o_busy[0], o_done[0]},
              {27'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
        step(); step();
        exp_rdata[0] = 8'h00;
        exp_rdata[1] = 8'h00;
        check("midop_rdata_cleared", {24'd0, o_rdata[0]}, 32'd0);
        for (int k = 0; k < 2; k++) rs0[k] = rsthi[k];
        reset_n = 1'b1;
        for (int i = 0; i < 3 * RSTC; i++) step();
        check("midop_no_done", donecnt[0] - d0[0], 0);
        for (int k = 0; k < 2; k++) begin
            check("midop_bus_rst_cycles", rsthi[k] - rs0[k], RSTC);
            check_idle_outputs(k);
        end
        run_txn(0, 2'd0, 8'h00, 8'($urandom), 8'($urandom), 1'b0);
        run_txn(1, 2'd1, 8'h00, 8'($urandom), 8'($urandom), 1'b0);

        check("data_stable_in_h_phases", unstable[0] + unstable[1], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
